// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: fetch FSM states, instruction width and branch opcodes.
package cpu_pkg;

  localparam int unsigned INST_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [3:0] JUMP   = 4'b1100;
  localparam logic [3:0] JUMPEQ = 4'b1101;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset, increment, and load (load beats increment).
module pc_reg #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: owns the PC, reads one word per step over req/ack, hands it to decode.
module fetch
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              next,
  input  logic              branch_take,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_data,
  output logic [INST_W-1:0] data_inst,
  output logic              decode_en,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   inst_pc
);

  fetch_state_t state_q, state_d;
  logic capture;
  logic pc_inc;
  logic pc_load;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (branch_target),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = FETCH;
      FETCH:   if (mem_ack) state_d = HOLD;
      HOLD:    if (next) state_d = run ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A redirect only lands when control leaves HOLD, so no wrong-path request is ever issued.
  always_comb begin
    mem_req = 1'b0;
    capture = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        capture = mem_ack;
        pc_inc  = mem_ack;
      end
      HOLD:    pc_load = next & branch_take;
      default: ;
    endcase
  end

  assign mem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_inst <= '0;
      inst_pc   <= '0;
      decode_en <= 1'b0;
    end else begin
      decode_en <= capture;
      if (capture) begin
        data_inst <= mem_data;
        inst_pc   <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: stimulus queues expected decode handoffs, a monitor checks each decode_en.
module tb_fetch;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] ipc;
    logic [15:0] npc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0, next = 1'b0, branch_take = 1'b0;
  logic [15:0] branch_target = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;
  logic [15:0] mem_addr, data_inst, pc, inst_pc;
  logic        mem_req, decode_en;

  logic        w_reset = 1'b1, w_run = 1'b0, w_next = 1'b0, w_bt = 1'b0, w_ack = 1'b0;
  logic [15:0] w_tgt = '0, w_mdata = '0;
  logic [15:0] w_mem_addr, w_data_inst, w_pc, w_inst_pc;
  logic        w_mem_req, w_decode_en;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          pushed = 0;
  int          popped = 0;
  logic [15:0] exp_pc = 16'h0000;
  logic [15:0] last_data = 16'h0000;

  always #5 clk = ~clk;

  fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .run(run), .next(next), .branch_take(branch_take),
    .branch_target(branch_target), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_data(mem_data), .data_inst(data_inst),
    .decode_en(decode_en), .pc(pc), .inst_pc(inst_pc)
  );

  fetch #(.PC_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(w_reset), .run(w_run), .next(w_next), .branch_take(w_bt),
    .branch_target(w_tgt), .mem_addr(w_mem_addr), .mem_req(w_mem_req),
    .mem_ack(w_ack), .mem_data(w_mdata), .data_inst(w_data_inst),
    .decode_en(w_decode_en), .pc(w_pc), .inst_pc(w_inst_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every decode_en strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && decode_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_decode_en actual=1 required=0 data_inst=%h", data_inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        chk("sb_data_inst", 32'(data_inst), 32'(e.data));
        chk("sb_inst_pc", 32'(inst_pc), 32'(e.ipc));
        chk("sb_pc", 32'(pc), 32'(e.npc));
      end
    end
  end

  // DUT is in FETCH: hold off ack for 'delay' cycles, then return 'data'.
  task automatic fetch_one(input logic [15:0] data, input int delay);
    for (int i = 0; i < delay; i++) begin
      chk("wait_mem_req", 32'(mem_req), 32'd1);
      chk("wait_mem_addr", 32'(mem_addr), 32'(exp_pc));
      chk("wait_data_inst", 32'(data_inst), 32'(last_data));
      step();
    end
    chk("ack_mem_req", 32'(mem_req), 32'd1);
    chk("ack_mem_addr", 32'(mem_addr), 32'(exp_pc));
    mem_ack  = 1'b1;
    mem_data = data;
    sb.push_back('{data: data, ipc: exp_pc, npc: 16'(exp_pc + 16'd1)});
    pushed++;
    step();
    mem_ack   = 1'b0;
    exp_pc    = 16'(exp_pc + 16'd1);
    last_data = data;
  endtask

  task automatic do_next(input logic take, input logic [15:0] target);
    next          = 1'b1;
    branch_take   = take;
    branch_target = target;
    step();
    next        = 1'b0;
    branch_take = 1'b0;
    if (take) exp_pc = target;
  endtask

  initial begin
    step();
    step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_inst_pc", 32'(inst_pc), 32'h0000);
    chk("rst_data_inst", 32'(data_inst), 32'h0000);
    chk("rst_decode_en", 32'(decode_en), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_mem_req", 32'(mem_req), 32'd0);

    // First fetch, zero-wait, then back-to-back with next in first HOLD cycle.
    run = 1'b1;
    step();
    fetch_one(16'h1234, 0);
    do_next(1'b0, 16'h0000);
    fetch_one(16'h5678, 0);

    // Wait states.
    do_next(1'b0, 16'h0000);
    fetch_one(16'hABCD, 3);

    // branch_take without next is ignored.
    branch_take   = 1'b1;
    branch_target = 16'h0077;
    step();
    step();
    branch_take = 1'b0;
    chk("nobr_mem_req", 32'(mem_req), 32'd0);
    chk("nobr_pc", 32'(pc), 32'(exp_pc));

    // Taken branch.
    do_next(1'b1, 16'h0040);
    chk("br_mem_addr", 32'(mem_addr), 32'h0040);
    fetch_one(16'h0F0F, 1);

    // Spurious ack in HOLD.
    mem_ack  = 1'b1;
    mem_data = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    chk("hold_ack_mem_req", 32'(mem_req), 32'd0);
    chk("hold_ack_pc", 32'(pc), 32'(exp_pc));
    chk("hold_ack_data", 32'(data_inst), 32'(last_data));

    // Stop to IDLE, spurious ack in IDLE, then resume.
    run = 1'b0;
    do_next(1'b0, 16'h0000);
    chk("stop_mem_req", 32'(mem_req), 32'd0);
    mem_ack  = 1'b1;
    mem_data = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    step();
    chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
    chk("idle_ack_pc", 32'(pc), 32'(exp_pc));
    chk("idle_ack_data", 32'(data_inst), 32'(last_data));
    run = 1'b1;
    step();
    chk("resume_mem_addr", 32'(mem_addr), 32'(exp_pc));
    fetch_one(16'h2222, 0);

    // Reset mid-fetch with a late ack.
    do_next(1'b0, 16'h0000);
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    run   = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_pc", 32'(pc), 32'h0000);
    mem_ack  = 1'b1;
    mem_data = 16'hFACE;
    step();
    mem_ack = 1'b0;
    step();
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    chk("late_ack_pc", 32'(pc), 32'h0000);
    chk("late_ack_data", 32'(data_inst), 32'h0000);
    chk("late_ack_inst_pc", 32'(inst_pc), 32'h0000);

    // Wrap-around on the RESET_PC=FFFF instance.
    chk("wrap_rst_addr", 32'(w_mem_addr), 32'hFFFF);
    w_reset = 1'b0;
    w_run   = 1'b1;
    step();
    chk("wrap_mem_req", 32'(w_mem_req), 32'd1);
    chk("wrap_mem_addr", 32'(w_mem_addr), 32'hFFFF);
    w_ack   = 1'b1;
    w_mdata = 16'h4321;
    step();
    w_ack = 1'b0;
    chk("wrap_decode_en", 32'(w_decode_en), 32'd1);
    chk("wrap_inst_pc", 32'(w_inst_pc), 32'hFFFF);
    chk("wrap_pc", 32'(w_pc), 32'h0000);
    chk("wrap_data", 32'(w_data_inst), 32'h4321);
    step();
    chk("wrap_pulse_end", 32'(w_decode_en), 32'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb_pop_count", 32'(popped), 32'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
